// File: rtl/bit_deserializer.sv
// -----------------------------------------------------------------------------
// bit_deserializer
//   Receive side of the two-bit serial link. Collects SYMBOL_BITS consecutive
//   valid bits into a symbol. The first bit received becomes the MSB. Each
//   completed symbol is pushed into a small show-ahead FIFO that a ready/valid
//   consumer drains.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_valid    serial bit qualifier, aligned with in_bit
//   in_bit      serial data bit
//   out_ready   consumer ready (ignored while the FIFO is empty)
//   out_valid   FIFO non-empty
//   out_data    FIFO head symbol, 0 when empty
//   fifo_level  entries held, 0..FIFO_DEPTH
//   frag_err    one-cycle pulse: a partial symbol was discarded
//   overflow    one-cycle pulse: a complete symbol was dropped (FIFO full)
//   sym_count   saturating count of symbols written into the FIFO
// -----------------------------------------------------------------------------
module bit_deserializer #(
  parameter int SYMBOL_BITS = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic                          in_bit,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [SYMBOL_BITS-1:0]        out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frag_err,
  output logic                          overflow,
  output logic [CNT_W-1:0]              sym_count
);

  localparam int IDX_W = $clog2(SYMBOL_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SYMBOL_BITS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

  // Assembly state
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [SYMBOL_BITS-2:0] shift_q, shift_d;
  logic [SYMBOL_BITS-2:0] shift_in;

  // FIFO state
  logic [SYMBOL_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [SYMBOL_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q,  level_d;

  // Status
  logic                   frag_q,   frag_d;
  logic                   ovf_q,    ovf_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;

  // Per-edge events
  logic                   sym_done;
  logic [SYMBOL_BITS-1:0] sym_word;
  logic                   fifo_full;
  logic                   pop;
  logic                   push;

  // The shift register only needs SYMBOL_BITS-1 bits: the final bit of a
  // symbol is taken straight from in_bit on the completing edge.
  generate
    if (SYMBOL_BITS == 2) begin : g_shift_min
      assign shift_in = in_bit;
    end else begin : g_shift_wide
      assign shift_in = {shift_q[SYMBOL_BITS-3:0], in_bit};
    end
  endgenerate

  always_comb begin
    sym_done  = in_valid && (idx_q == LAST_IDX);
    sym_word  = {shift_q, in_bit};
    fifo_full = (level_q == FULL_LVL);
    // Pop decision uses registered level only, so a symbol pushed into an
    // empty FIFO is never popped on the edge that writes it.
    pop       = (level_q != '0) && out_ready;
    // A full FIFO still accepts a push when a pop frees a slot on that edge.
    push      = sym_done && (!fifo_full || pop);
  end

  // Symbol assembly and fragment detection
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    frag_d  = 1'b0;
    if (in_valid) begin
      shift_d = shift_in;
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else if (idx_q != '0) begin
      idx_d  = '0;
      frag_d = 1'b1;
    end
  end

  // FIFO pointers, storage, level and counters
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    ovf_d    = sym_done && fifo_full && !pop;

    if (push) begin
      mem_d[wr_ptr_q] = sym_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      frag_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      frag_q   <= frag_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Outputs depend only on registered state
  always_comb begin
    out_valid  = (level_q != '0);
    out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    fifo_level = level_q;
    frag_err   = frag_q;
    overflow   = ovf_q;
    sym_count  = cnt_q;
  end

endmodule

// File: tb/tb_bit_deserializer.sv
module tb_bit_deserializer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_bit;
  logic        out_ready;
  logic        out_valid;
  logic [1:0]  out_data;
  logic [2:0]  fifo_level;
  logic        frag_err;
  logic        overflow;
  logic [15:0] sym_count;

  logic        s_out_valid;
  logic [1:0]  s_out_data;
  logic [2:0]  s_fifo_level;
  logic        s_frag_err;
  logic        s_overflow;
  logic [2:0]  s_sym_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  bit_deserializer #(.SYMBOL_BITS(2), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .fifo_level(fifo_level), .frag_err(frag_err), .overflow(overflow),
    .sym_count(sym_count)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  bit_deserializer #(.SYMBOL_BITS(2), .FIFO_DEPTH(4), .CNT_W(3)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .out_ready(out_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .fifo_level(s_fifo_level), .frag_err(s_frag_err), .overflow(s_overflow),
    .sym_count(s_sym_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_pair(input logic [1:0] s);
    send_bit(s[1]);
    send_bit(s[0]);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    tick(); tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 2'b00) $display("FAIL reset_out_data got=%b exp=00", out_data); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", fifo_level); else pass_cnt++;
    total_cnt++; if (sym_count !== 16'd0) $display("FAIL reset_sym_count got=%0d exp=0", sym_count); else pass_cnt++;
    total_cnt++; if ({frag_err, overflow} !== 2'b00) $display("FAIL reset_pulses got=%b exp=00", {frag_err, overflow}); else pass_cnt++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_bit(1'b1);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_half_valid got=%b exp=0", out_valid); else pass_cnt++;
    send_bit(1'b0);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 2'b10) $display("FAIL basic_data got=%b exp=10", out_data); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd1) $display("FAIL basic_level got=%0d exp=1", fifo_level); else pass_cnt++;
    total_cnt++; if (sym_count !== 16'd1) $display("FAIL basic_sym_count got=%0d exp=1", sym_count); else pass_cnt++;
    idle();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_popped got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (frag_err !== 1'b0) $display("FAIL basic_frag got=%b exp=0", frag_err); else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [1:0] exp_q [3];
    exp_q[0] = 2'b11; exp_q[1] = 2'b01; exp_q[2] = 2'b00;
    out_ready = 1'b0;
    send_pair(2'b11); send_pair(2'b01); send_pair(2'b00);
    idle();
    total_cnt++; if (fifo_level !== 3'd3) $display("FAIL stream_level got=%0d exp=3", fifo_level); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (out_data !== exp_q[i]) $display("FAIL stream_head%0d got=%b exp=%b", i, out_data, exp_q[i]); else pass_cnt++;
      idle();
    end
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_drained got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 2'b00) $display("FAIL stream_empty_data got=%b exp=00", out_data); else pass_cnt++;
    total_cnt++; if (sym_count !== 16'd4) $display("FAIL stream_sym_count got=%0d exp=4", sym_count); else pass_cnt++;
  endtask

  task automatic test_fragment();
    out_ready = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    total_cnt++; if (frag_err !== 1'b0) $display("FAIL frag_early got=%b exp=0", frag_err); else pass_cnt++;
    idle();
    total_cnt++; if (frag_err !== 1'b1) $display("FAIL frag_pulse got=%b exp=1", frag_err); else pass_cnt++;
    total_cnt++; if (out_data !== 2'b01) $display("FAIL frag_first_sym got=%b exp=01", out_data); else pass_cnt++;
    idle();
    total_cnt++; if (frag_err !== 1'b0) $display("FAIL frag_one_cycle got=%b exp=0", frag_err); else pass_cnt++;
    send_pair(2'b11);
    total_cnt++; if (fifo_level !== 3'd2) $display("FAIL frag_level got=%0d exp=2", fifo_level); else pass_cnt++;
    out_ready = 1'b1;
    idle();
    total_cnt++; if (out_data !== 2'b11) $display("FAIL frag_clean_sym got=%b exp=11", out_data); else pass_cnt++;
    idle();
    out_ready = 1'b0;
    total_cnt++; if (sym_count !== 16'd6) $display("FAIL frag_sym_count got=%0d exp=6", sym_count); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [1:0] a [4];
    logic [1:0] b [4];
    a[0] = 2'b00; a[1] = 2'b01; a[2] = 2'b10; a[3] = 2'b11;
    b[0] = 2'b11; b[1] = 2'b10; b[2] = 2'b01; b[3] = 2'b00;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(a[i]);
    total_cnt++; if (fifo_level !== 3'd4) $display("FAIL ovf_full_level got=%0d exp=4", fifo_level); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_early got=%b exp=0", overflow); else pass_cnt++;
    send_pair(2'b01);
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_pulse got=%b exp=1", overflow); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd4) $display("FAIL ovf_level got=%0d exp=4", fifo_level); else pass_cnt++;
    total_cnt++; if (sym_count !== 16'd10) $display("FAIL ovf_sym_count got=%0d exp=10", sym_count); else pass_cnt++;
    idle();
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_one_cycle got=%b exp=0", overflow); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (out_data !== a[i]) $display("FAIL ovf_intact%0d got=%b exp=%b", i, out_data, a[i]); else pass_cnt++;
      idle();
    end
    total_cnt++; if (fifo_level !== 3'd0) $display("FAIL ovf_drained got=%0d exp=0", fifo_level); else pass_cnt++;

    // Full FIFO with a simultaneous pop accepts the new symbol.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(b[i]);
    send_bit(1'b1);
    out_ready = 1'b1;
    send_bit(1'b0);
    out_ready = 1'b0;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_pop_none got=%b exp=0", overflow); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd4) $display("FAIL ovf_pop_level got=%0d exp=4", fifo_level); else pass_cnt++;
    total_cnt++; if (out_data !== 2'b10) $display("FAIL ovf_pop_head got=%b exp=10", out_data); else pass_cnt++;
    total_cnt++; if (sym_count !== 16'd15) $display("FAIL ovf_pop_sym_count got=%0d exp=15", sym_count); else pass_cnt++;
    out_ready = 1'b1;
    idle(); idle(); idle();
    total_cnt++; if (out_data !== 2'b10) $display("FAIL ovf_pop_tail got=%b exp=10", out_data); else pass_cnt++;
    idle();
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL ovf_pop_drained got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_pair(2'b10); send_pair(2'b11); send_pair(2'b01);
    send_bit(1'b1);
    total_cnt++; if (fifo_level !== 3'd3) $display("FAIL rstmid_pre_level got=%0d exp=3", fifo_level); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_async_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd0) $display("FAIL rstmid_async_level got=%0d exp=0", fifo_level); else pass_cnt++;
    total_cnt++; if (out_data !== 2'b00) $display("FAIL rstmid_async_data got=%b exp=00", out_data); else pass_cnt++;
    total_cnt++; if (sym_count !== 16'd0) $display("FAIL rstmid_async_cnt got=%0d exp=0", sym_count); else pass_cnt++;
    tick();
    reset_n = 1'b1;
    send_pair(2'b01);
    total_cnt++; if (fifo_level !== 3'd1) $display("FAIL rstmid_level got=%0d exp=1", fifo_level); else pass_cnt++;
    total_cnt++; if (out_data !== 2'b01) $display("FAIL rstmid_data got=%b exp=01", out_data); else pass_cnt++;
    total_cnt++; if (frag_err !== 1'b0) $display("FAIL rstmid_frag got=%b exp=0", frag_err); else pass_cnt++;
    idle();
    total_cnt++; if (frag_err !== 1'b0) $display("FAIL rstmid_frag_late got=%b exp=0", frag_err); else pass_cnt++;
    total_cnt++; if (sym_count !== 16'd1) $display("FAIL rstmid_sym_count got=%0d exp=1", sym_count); else pass_cnt++;
  endtask

  task automatic test_saturation();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_pair(2'b10);
    idle();
    total_cnt++; if (s_sym_count !== 3'd7) $display("FAIL sat_count got=%0d exp=7", s_sym_count); else pass_cnt++;
    total_cnt++; if (sym_count !== 16'd9) $display("FAIL sat_wide_count got=%0d exp=9", sym_count); else pass_cnt++;
    total_cnt++; if (s_fifo_level !== 3'd0) $display("FAIL sat_level got=%0d exp=0", s_fifo_level); else pass_cnt++;
    total_cnt++; if (s_overflow !== 1'b0) $display("FAIL sat_overflow got=%b exp=0", s_overflow); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_streaming();
    test_fragment();
    test_overflow();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
- Receive side of the two-bit serial link: accepts the registered `in_bit`/`in_valid` stream produced by the link serializer and reassembles symbols.
- Each symbol is SYMBOL_BITS consecutive valid bits, first bit = v1, then v2, and so on.
- Completed symbols go into a small show-ahead FIFO drained by a ready/valid consumer.
- Reports fragment errors and overflows, and keeps a saturating count of symbols received.

Parameters:
- SYMBOL_BITS, 2, bits per symbol; >= 2. First bit received lands in out_data[SYMBOL_BITS-1].
- FIFO_DEPTH, 4, symbol FIFO entries; power of two, >= 2.
- CNT_W, 16, width of sym_count.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  serial bit qualifier, aligned with in_bit.
- in_bit  in  1  serial data bit.
- out_ready  in  1  consumer ready.
- out_valid  out  1  FIFO non-empty.
- out_data  out  SYMBOL_BITS  FIFO head symbol; {v1,v2} for the default.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held, 0..FIFO_DEPTH.
- frag_err  out  1  one-cycle pulse: partial symbol discarded.
- overflow  out  1  one-cycle pulse: complete symbol dropped because the FIFO was full.
- sym_count  out  CNT_W  symbols written to the FIFO, saturating.

Behaviour:
- Reset (reset_n low, asynchronous):
  - bit index, shift register, FIFO pointers, fifo_level, sym_count, frag_err and overflow all clear immediately.
  - out_valid=0, out_data=0.
  - A partial symbol in progress at reset is discarded silently, with no frag_err.
  - Operation resumes on the first clk edge after reset_n rises.
- Assembly:
  - On each edge with in_valid=1: shift in_bit into the LSB of the shift register; bit index increments.
  - When the bit index equals SYMBOL_BITS-1 on a valid edge, the symbol is complete: {shift register, in_bit} is written to the FIFO on that same edge and the index returns to 0.
  - Back-to-back symbols with no gap are supported; in_valid held high for 2N cycles yields N symbols.
- Fragment:
  - An edge with in_valid=0 and bit index != 0 sets the index to 0 and discards the partial bits.
  - frag_err is high for exactly the following cycle.
  - in_valid=0 with index 0 is idle: no effect, in_bit ignored.
- FIFO:
  - Show-ahead: out_data always shows the head entry, and is 0 when empty. out_valid = (fifo_level != 0), taken from registered state.
  - Pop on an edge with out_valid && out_ready. out_ready is ignored while empty.
  - Latency: last bit of a symbol sampled at edge k, so out_valid and out_data are valid in the cycle after edge k (one cycle).
  - Push and pop on the same edge: level unchanged. This includes the full case, where the push is accepted because a slot frees.
  - Push while full with no pop: the new symbol is dropped, FIFO contents are unchanged, overflow pulses high for the next cycle, and sym_count is not incremented.
  - Push into an empty FIFO with out_ready=1: the entry is not popped on the same edge. It becomes visible first and is popped on a later edge.
  - Pointers wrap modulo FIFO_DEPTH.
- sym_count: increments by 1 on each accepted FIFO write and holds at 2^CNT_W-1.
- frag_err and overflow cannot both assert for the same edge: a fragment needs in_valid=0, while a completion needs in_valid=1.
- No combinational path from in_* to any output. out_data is a FIFO read mux of registered storage.

Test Plan:
- Basic pair: reset, then in_valid=1 for 2 cycles with in_bit 1 then 0, out_ready=1 -> one cycle after the 2nd bit: out_valid=1, out_data=2'b10, fifo_level=1; popped next edge; sym_count=1; frag_err never high.
- Streaming: in_valid high for 6 cycles with bits 1,1,0,1,0,0 and out_ready=0 -> FIFO holds 2'b11, 2'b01, 2'b00 in order, fifo_level=3; then out_ready=1 drains those three values over 3 edges and out_valid falls.
- Fragment: in_valid=1 for 3 cycles (bits 0,1,1) then 0 -> symbol 2'b01 pushed; third bit discarded; frag_err pulses exactly 1 cycle; the next clean pair (1,1) yields 2'b11.
- Overflow: out_ready=0, push 5 pairs with FIFO_DEPTH=4 -> fifo_level=4, one overflow pulse on the 5th completion, sym_count=4, first 4 symbols intact. Repeat with out_ready=1 on the 5th completion edge -> no overflow, level stays 4.
- Reset mid-symbol: assert reset_n=0 asynchronously after 1 bit with 3 entries queued -> outputs clear immediately with no clock; after release, a pair (0,1) yields 2'b01 as the sole entry and frag_err stays 0.
- Saturation: CNT_W=3, push 9 symbols while draining -> sym_count stops at 7.
